// File: rtl/gray2bin_arbiter.sv
// Round-robin scheduler that feeds N_REQ Gray-coded requesters into one
// bit-serial Gray-to-binary converter (MSB first) with a valid/ready result port.
//
//  state | meaning
//  ------+----------------------------------------------------------
//  IDLE  | waiting for any req; arbitrates and captures the winner's code
//  CONV  | resolves one binary bit per clock, bit idx, MSB first
//  HOLD  | result presented on bin_out/out_id until out_valid & out_ready
module gray2bin_arbiter #(
    parameter  int N_REQ = 4,
    parameter  int W     = 4,
    localparam int IDW   = $clog2(N_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*W-1:0] gray_in,
    output logic [N_REQ-1:0]   grant,
    output logic               busy,
    output logic [W-1:0]       bin_out,
    output logic [IDW-1:0]     out_id,
    output logic               out_valid,
    input  logic               out_ready
);

    localparam int IXW = $clog2(W + 1);
    localparam logic [N_REQ-1:0] GRANT_LSB = N_REQ'(1);

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        HOLD
    } state_t;

    state_t         state;
    logic [W-1:0]   g_reg;
    logic [W-1:0]   bin_reg;
    logic [IXW-1:0] idx;
    logic [IDW-1:0] last_id;

    logic [W-1:0]   gray_arr [N_REQ];
    logic           win_found;
    logic [IDW-1:0] win_id;
    logic [W-1:0]   win_gray;
    int             cand_i;

    logic [W:0]     bin_ext;
    logic [W:0]     g_ext;
    logic           next_bit;
    logic [W-1:0]   bin_next;

    // Search starts one past the last winner, so a requester that keeps req
    // high after its grant naturally falls to the back of the queue.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        win_gray  = '0;
        cand_i    = 0;
        for (int k = 0; k < N_REQ; k++) begin
            gray_arr[k] = gray_in[k*W +: W];
        end
        for (int off = 1; off <= N_REQ; off++) begin
            cand_i = (int'(last_id) + off) % N_REQ;
            if (!win_found && req[IDW'(cand_i)]) begin
                win_found = 1'b1;
                win_id    = IDW'(cand_i);
                win_gray  = gray_arr[IDW'(cand_i)];
            end
        end
    end

    // Zero above the MSB makes bit W-1 fall out of the same XOR as the rest.
    always_comb begin
        bin_ext  = {1'b0, bin_reg};
        g_ext    = {1'b0, g_reg};
        next_bit = bin_ext[idx + 1'b1] ^ g_ext[idx];
        bin_next = bin_reg;
        for (int i = 0; i < W; i++) begin
            if (idx == IXW'(i)) begin
                bin_next[i] = next_bit;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            grant     <= '0;
            out_valid <= 1'b0;
            out_id    <= '0;
            last_id   <= IDW'(N_REQ - 1);
            g_reg     <= '0;
            bin_reg   <= '0;
            idx       <= '0;
        end else begin
            grant <= '0;
            case (state)
                IDLE: begin
                    if (win_found) begin
                        grant   <= GRANT_LSB << win_id;
                        g_reg   <= win_gray;
                        out_id  <= win_id;
                        last_id <= win_id;
                        idx     <= IXW'(W - 1);
                        state   <= CONV;
                    end
                end
                CONV: begin
                    bin_reg <= bin_next;
                    if (idx == '0) begin
                        out_valid <= 1'b1;
                        state     <= HOLD;
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy    = (state != IDLE);
    assign bin_out = bin_reg;

endmodule

// File: tb/tb_gray2bin_arbiter.sv
// Self-checking bench for gray2bin_arbiter: vector table plus hand-written
// sequences for round-robin, backpressure, reset abort and withdrawn requests.
module tb_gray2bin_arbiter;

    localparam int N_REQ = 4;
    localparam int W     = 4;
    localparam int IDW   = 2;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [N_REQ-1:0]   req = '0;
    logic [N_REQ*W-1:0] gray_in = '0;
    logic               out_ready = 1'b0;
    logic [N_REQ-1:0]   grant;
    logic               busy;
    logic [W-1:0]       bin_out;
    logic [IDW-1:0]     out_id;
    logic               out_valid;

    gray2bin_arbiter #(.N_REQ(N_REQ), .W(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .gray_in  (gray_in),
        .grant    (grant),
        .busy     (busy),
        .bin_out  (bin_out),
        .out_id   (out_id),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [IDW-1:0] id;
        logic [W-1:0]   bin;
    } exp_t;

    typedef struct {
        int           id;
        logic [W-1:0] gray;
        logic [W-1:0] bin;
    } vec_t;

    int     n_checks = 0;
    int     n_fail   = 0;
    exp_t   sb_q[$];
    vec_t   vecs[21];
    logic   grant3_seen = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int id, input logic [W-1:0] b);
        exp_t e;
        e.id  = IDW'(id);
        e.bin = b;
        sb_q.push_back(e);
    endtask

    task automatic wait_grant(input int max_cyc, output int cyc);
        cyc = 0;
        while (grant == '0 && cyc < max_cyc) begin
            step();
            cyc++;
        end
        check("grant_seen", (grant != '0), 1);
    endtask

    task automatic wait_valid(input int max_cyc);
        int cyc;
        cyc = 0;
        while (!out_valid && cyc < max_cyc) begin
            step();
            cyc++;
        end
        check("valid_seen", out_valid, 1);
    endtask

    task automatic wait_idle(input int max_cyc);
        int cyc;
        cyc = 0;
        while (busy && cyc < max_cyc) begin
            step();
            cyc++;
        end
        check("idle_reached", busy, 0);
    endtask

    task automatic run_vec(input int id, input logic [W-1:0] g, input logic [W-1:0] b);
        int c;
        gray_in[id*W +: W] = g;
        req = '0;
        req[id] = 1'b1;
        push_exp(id, b);
        wait_grant(8, c);
        check("vec_grant", grant, 32'(1) << id);
        req = '0;
        wait_valid(8);
        check("vec_bin", bin_out, b);
        check("vec_id", out_id, id);
        step();
        check("vec_done", out_valid, 0);
    endtask

    // Scoreboard pops on every transfer; grant must never be multi-hot.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            check("grant_onehot", $onehot0(grant), 1);
            if (grant[3]) grant3_seen = 1'b1;
            if (out_valid && out_ready) begin
                check("sb_nonempty", (sb_q.size() != 0), 1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    check("sb_bin", bin_out, e.bin);
                    check("sb_id", out_id, e.id);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   c;
        int   t;
        int   t_grant[6];
        int   rr_order[6];
        logic [3:0] iv;

        rr_order = '{0, 1, 2, 3, 0, 1};

        // Reset values
        rst = 1'b1;
        repeat (2) step();
        check("rst_grant", grant, 0);
        check("rst_busy", busy, 0);
        check("rst_valid", out_valid, 0);
        check("rst_bin", bin_out, 0);
        check("rst_id", out_id, 0);
        rst = 1'b0;
        step();

        // Single conversion with latency trace
        gray_in[3:0] = 4'b1101;
        req = 4'b0001;
        push_exp(0, 4'b1001);
        step();
        check("single_grant", grant, 4'b0001);
        check("single_busy", busy, 1);
        req = '0;
        step();
        check("single_grant_pulse", grant, 0);
        check("single_valid_e1", out_valid, 0);
        for (int i = 0; i < 2; i++) begin
            step();
            check("single_valid_early", out_valid, 0);
        end
        step();
        check("single_valid_e4", out_valid, 1);
        check("single_bin", bin_out, 4'b1001);
        check("single_id", out_id, 0);
        out_ready = 1'b1;
        step();
        check("single_xfer_valid", out_valid, 0);
        check("single_xfer_busy", busy, 0);

        // Vector table: exhaustive requester 2 plus explicit codes
        for (int i = 0; i < 16; i++) begin
            iv = 4'(i);
            vecs[i] = '{2, iv ^ (iv >> 1), iv};
        end
        vecs[16] = '{2, 4'b1000, 4'b1111};
        vecs[17] = '{2, 4'b0110, 4'b0100};
        vecs[18] = '{0, 4'b0101, 4'b0110};
        vecs[19] = '{1, 4'b0011, 4'b0010};
        vecs[20] = '{3, 4'b1111, 4'b1010};
        for (int i = 0; i < 21; i++) begin
            run_vec(vecs[i].id, vecs[i].gray, vecs[i].bin);
        end
        wait_idle(10);

        // Round-robin with all requesters held high
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        gray_in = {4'b0110, 4'b0010, 4'b0011, 4'b0001};
        for (int n = 0; n < 6; n++) begin
            push_exp(rr_order[n], (rr_order[n] == 0) ? 4'b0001 : (rr_order[n] == 1) ? 4'b0010 :
                                  (rr_order[n] == 2) ? 4'b0011 : 4'b0100);
        end
        req = 4'b1111;
        t = 0;
        for (int n = 0; n < 6; n++) begin
            do begin
                step();
                t++;
            end while (grant == '0 && t < 100);
            t_grant[n] = t;
            check("rr_grant", grant, 32'(1) << rr_order[n]);
            if (n > 0) check("rr_spacing", t_grant[n] - t_grant[n-1], 6);
            if (n == 5) req = '0;
        end
        wait_idle(20);
        step();

        // Backpressure: result held, pending req[1] waits for the transfer
        out_ready = 1'b0;
        push_exp(0, 4'b0001);
        push_exp(1, 4'b0010);
        req = 4'b0001;
        wait_grant(8, c);
        check("bp_grant0", grant, 4'b0001);
        req = 4'b0010;
        wait_valid(8);
        for (int i = 0; i < 10; i++) begin
            step();
            check("bp_bin_stable", bin_out, 4'b0001);
            check("bp_id_stable", out_id, 0);
            check("bp_valid_held", out_valid, 1);
            check("bp_no_grant", grant, 0);
        end
        out_ready = 1'b1;
        step();
        check("bp_xfer_grant", grant, 0);
        check("bp_xfer_valid", out_valid, 0);
        step();
        check("bp_next_grant", grant, 4'b0010);
        req = '0;
        wait_valid(8);
        step();
        wait_idle(10);

        // Reset during the second CONV cycle discards the result
        req = 4'b0001;
        wait_grant(8, c);
        req = '0;
        step();
        #2;
        rst = 1'b1;
        #1;
        check("rstmid_grant", grant, 0);
        check("rstmid_busy", busy, 0);
        check("rstmid_valid", out_valid, 0);
        check("rstmid_bin", bin_out, 0);
        check("rstmid_id", out_id, 0);
        for (int i = 0; i < 2; i++) begin
            step();
            check("rstmid_no_valid", out_valid, 0);
        end
        rst = 1'b0;
        req = 4'b1111;
        push_exp(0, 4'b0001);
        wait_grant(8, c);
        check("rstmid_first_grant", grant, 4'b0001);
        req = '0;
        wait_valid(8);
        step();
        wait_idle(10);

        // Withdrawn request: req[3] pulsed for one cycle while busy
        grant3_seen = 1'b0;
        req = 4'b0001;
        push_exp(0, 4'b0001);
        wait_grant(8, c);
        req = '0;
        step();
        req = 4'b1000;
        check("wd_busy", busy, 1);
        step();
        req = '0;
        wait_valid(8);
        step();
        wait_idle(10);
        repeat (5) step();
        check("wd_no_grant3", grant3_seen, 0);

        check("sb_drained", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gray2bin_arbiter.md
# gray2bin_arbiter

Shared-resource scheduler for the 4-bit Gray-to-binary conversion path. Up to N_REQ requesters each present a Gray code. The block grants them round-robin into a single bit-serial converter that resolves one binary bit per clock, MSB first. It returns the binary result tagged with the requester index over a valid/ready output handshake. It sits between Gray-coded sources (pointers, encoders, counters) and the binary consumers that read them.

## Interface
- N_REQ, 4, number of requesters; legal range 2..8.
- W, 4, Gray/binary word width; legal range 2..16.
- IDW, derived = clog2(N_REQ), width of out_id.

- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  reset, asynchronous, active-high.
- req  in  N_REQ  per-requester request level; bit k is held high until grant[k].
- gray_in  in  N_REQ*W  requester k's code is at bits [k*W+W-1 : k*W]; sampled only on the grant edge.
- grant  out  N_REQ  one-hot, registered, high for exactly one cycle per accepted request.
- busy  out  1  high whenever the FSM is not in IDLE.
- bin_out  out  W  converted binary word; valid while out_valid is high.
- out_id  out  IDW  index of the requester that owns bin_out.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts; a transfer occurs on an edge where out_valid and out_ready are both high.

## Operation
- The FSM has three states: IDLE, CONV and HOLD.
- **IDLE**
  - On an edge with req != 0, select the winner k by round-robin, starting from (last_id+1) mod N_REQ and searching upward with wrap.
  - On that edge: capture gray_in slice k into g_reg, set grant[k], set out_id = k and last_id = k, load bit index idx = W-1, and go to CONV.
  - On an edge with req == 0, stay in IDLE.
- **CONV**
  - Each edge computes one bit: bin_reg[W-1] = g_reg[W-1]; for i < W-1, bin_reg[i] = bin_reg[i+1] XOR g_reg[i].
  - idx decrements after each bit.
  - On the edge that computes bit 0, go to HOLD and set out_valid.
- **HOLD**
  - bin_out, out_id and out_valid are held stable until a transfer.
  - On the transfer edge, clear out_valid and go to IDLE.
  - The next grant can occur at the earliest on the following edge.
- Requests arriving during CONV or HOLD are not granted. They stay pending, since requesters hold req, and arbitration sees them on the next IDLE edge.
- A requester that keeps req high after its grant is treated as a new request. Round-robin still places it last among the contenders.
- bin_out is driven from bin_reg. Bits not yet computed during CONV are don't-care and must not be consumed.

## Timing
- Reset values:
  - grant = 0, busy = 0, out_valid = 0, bin_out = 0, out_id = 0.
  - State = IDLE, last_id = N_REQ-1, so requester 0 wins first.
- Latency, measured from the edge at which the request is sampled in IDLE (edge E0):
  - grant is high from E0 to E1.
  - busy rises at E0.
  - Bits W-1..0 are produced at edges E1..EW.
  - out_valid rises at EW.
- Throughput: at most one conversion per W+2 cycles when out_ready is held high (E0 grant, W CONV edges, transfer edge at EW+1, next grant at EW+2).
- out_ready may already be high when out_valid rises; the transfer then happens at EW+1.
- A requester that drops req before being granted withdraws it; no grant is issued to it.
- Reset asserted mid-CONV or mid-HOLD:
  - All outputs clear immediately (asynchronously).
  - The in-flight result is discarded, with no out_valid pulse.
  - last_id returns to N_REQ-1.
- Simultaneous requests: exactly one grant per arbitration. No grant pulse is ever multi-hot.

## Test plan
- Single conversion: req = 0001 with gray_in[3:0] = 4'b1101.
  - grant = 0001 for one cycle.
  - bin_out = 4'b1001, out_id = 0, out_valid exactly 4 cycles after grant rises.
- Exhaustive: requester 2 converts every 4-bit code g = i^(i>>1), i = 0..15, with out_ready = 1.
  - bin_out = i and out_id = 2 for every code.
  - Codes 4'b1000 -> 4'b1111 and 4'b0110 -> 4'b0100 are checked explicitly.
- Round-robin: all four req held high continuously, out_ready = 1.
  - Grant order is 0, 1, 2, 3, 0, 1.
  - Grant-to-grant spacing is 6 cycles.
- Backpressure: out_ready = 0 for 10 cycles after out_valid rises, with req[1] pending.
  - bin_out and out_id stay stable and no new grant occurs.
  - After out_ready is raised, grant[1] follows on the next edge after the transfer.
- Reset mid-operation: assert rst at the 2nd CONV cycle.
  - All outputs are 0 immediately and out_valid never pulses.
  - After release with req = 1111, grant = 0001 first.
- Withdrawn request: req[3] pulsed for one cycle while busy; no grant[3] is ever issued.
